// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with x0 hard-wired to zero.
// A reset starts a hardware clear sweep; ready rises once every register holds zero.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = $clog2(NREGS),
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wen,
   input  logic [AW-1:0]       rd,
   input  logic [XLEN-1:0]     din,
   input  logic [NRD*AW-1:0]   rs,
   output logic [NRD*XLEN-1:0] rdata,
   output logic                ready
);

   typedef enum logic {CLEAR, READY} state_t;

   state_t          state_reg;
   logic [AW-1:0]   cnt_reg;

   // x0 has no storage behind it; reads of index 0 are forced to zero below.
   logic [XLEN-1:0] mem [1:NREGS-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= CLEAR;
         cnt_reg   <= AW'(1);
      end else if (state_reg == CLEAR) begin
         if (cnt_reg == AW'(NREGS-1)) begin
            state_reg <= READY;
         end else begin
            cnt_reg <= cnt_reg + AW'(1);
         end
      end
   end

   // Storage is left alone on reset edges; the sweep owns the write port until READY.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_reg == CLEAR) begin
            mem[cnt_reg] <= '0;
         end else if (wen && (rd != '0)) begin
            mem[rd] <= din;
         end
      end
   end

   assign ready = (state_reg == READY) && !rst;

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] rval;

      assign idx = rs[gi*AW +: AW];

      always_comb begin
         rval = '0;
         if ((state_reg == READY) && (idx != '0)) begin
            if ((BYPASS != 0) && wen && (rd == idx)) begin
               rval = din;
            end else begin
               rval = mem[idx];
            end
         end
      end

      assign rdata[gi*XLEN +: XLEN] = rval;
   end

endmodule
